// File: rtl/score_calculator_multi.sv
// score_calculator_multi: multi-lane reaction-game scorer with decaying lane points,
// a shared combo multiplier, a saturating score and a saturating miss tally.
module score_calculator_multi #(
    parameter int LANES     = 4,
    parameter int PAT_W     = 8,
    parameter int PT_W      = 4,
    parameter int MAX_PT    = 10,
    parameter int DECAY_DIV = 1,
    parameter int COMBO_W   = 4,
    parameter int COMBO_MAX = 3,
    parameter int SCORE_W   = 11,
    parameter int MISS_W    = 8
) (
    input  logic                   clock100m,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic [LANES-1:0]       write100m,
    input  logic [LANES*PAT_W-1:0] pattern,
    input  logic [LANES*PAT_W-1:0] user_input,
    output logic [SCORE_W-1:0]     score_out,
    output logic [LANES*PAT_W-1:0] pattern_out,
    output logic [COMBO_W-1:0]     combo_out,
    output logic [MISS_W-1:0]      miss_count,
    output logic [LANES-1:0]       hit_pulse,
    output logic                   saturated
);
    localparam int PS_W = DECAY_DIV > 1 ? $clog2(DECAY_DIV) : 1;
    localparam int CW   = $clog2(LANES + 1);
    localparam int SW   = SCORE_W + 2;
    localparam int CB   = COMBO_W + CW;
    localparam int MB   = MISS_W + CW;

    typedef enum logic {IDLE, ARMED} state_e;

    state_e                      state_q [LANES];
    state_e                      state_d [LANES];
    logic [LANES-1:0][PAT_W-1:0] pat_q, pat_d;
    logic [LANES-1:0][PT_W-1:0]  pts_q, pts_d;
    logic [PS_W-1:0]             ps_q, ps_d;
    logic [SCORE_W-1:0]          score_q, score_d;
    logic [COMBO_W-1:0]          combo_q, combo_d;
    logic [MISS_W-1:0]           miss_q, miss_d;
    logic [LANES-1:0]            hit, miss, hit_q;
    logic                        sat_q, clip, tick;
    logic [SW-1:0]               mult, sum, total;
    logic [CW-1:0]               n_hit, n_miss;
    logic [CB-1:0]               combo_sum;
    logic [MB-1:0]               miss_sum;

    assign tick = ps_q == PS_W'(DECAY_DIV - 1);
    assign ps_d = tick ? '0 : ps_q + PS_W'(1);

    // Per-lane priority: hit, wrong input, rearm, decay/timeout.
    always_comb begin
        hit = '0;
        miss = '0;
        pat_d = pat_q;
        pts_d = pts_q;
        for (int i = 0; i < LANES; i++) begin
            state_d[i] = state_q[i];
            if (state_q[i] == ARMED && write100m[i]) begin
                if (user_input[i*PAT_W +: PAT_W] == pat_q[i]) begin
                    hit[i] = 1'b1;
                    state_d[i] = IDLE;
                    pat_d[i] = '0;
                    pts_d[i] = '0;
                end else begin
                    miss[i] = 1'b1;
                end
            end else if (pattern[i*PAT_W +: PAT_W] != '0) begin
                miss[i] = state_q[i] == ARMED;
                state_d[i] = ARMED;
                pat_d[i] = pattern[i*PAT_W +: PAT_W];
                pts_d[i] = PT_W'(MAX_PT);
            end else if (state_q[i] == ARMED && tick) begin
                if (pts_q[i] != '0) begin
                    pts_d[i] = pts_q[i] - PT_W'(1);
                end else begin
                    miss[i] = 1'b1;
                    state_d[i] = IDLE;
                    pat_d[i] = '0;
                end
            end
        end
    end

    // Every hitting lane uses the multiplier from the start-of-cycle combo.
    always_comb begin
        mult = SW'(1) + ((SW'(combo_q) > SW'(COMBO_MAX)) ? SW'(COMBO_MAX) : SW'(combo_q));
        sum = '0;
        n_hit = '0;
        n_miss = '0;
        for (int i = 0; i < LANES; i++) begin
            if (hit[i]) sum = sum + SW'(pts_q[i]) * mult;
            n_hit = n_hit + CW'(hit[i]);
            n_miss = n_miss + CW'(miss[i]);
        end
        total = SW'(score_q) + sum;
        clip = total > SW'({SCORE_W{1'b1}});
        score_d = clip ? '1 : total[SCORE_W-1:0];
        combo_sum = CB'(combo_q) + CB'(n_hit);
        combo_d = n_miss != '0 ? '0 : (combo_sum > CB'({COMBO_W{1'b1}}) ? '1 : combo_sum[COMBO_W-1:0]);
        miss_sum = MB'(miss_q) + MB'(n_miss);
        miss_d = miss_sum > MB'({MISS_W{1'b1}}) ? '1 : miss_sum[MISS_W-1:0];
    end

    always_ff @(posedge clock100m or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LANES; i++) state_q[i] <= IDLE;
            pat_q <= '0;
            pts_q <= '0;
            ps_q <= '0;
            score_q <= '0;
            combo_q <= '0;
            miss_q <= '0;
            hit_q <= '0;
            sat_q <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) state_q[i] <= clear ? IDLE : state_d[i];
            pat_q <= clear ? '0 : pat_d;
            pts_q <= clear ? '0 : pts_d;
            ps_q <= clear ? '0 : ps_d;
            score_q <= clear ? '0 : score_d;
            combo_q <= clear ? '0 : combo_d;
            miss_q <= clear ? '0 : miss_d;
            hit_q <= clear ? '0 : hit;
            sat_q <= !clear && (sat_q || clip);
        end
    end

    assign score_out = score_q;
    assign pattern_out = pat_q;
    assign combo_out = combo_q;
    assign miss_count = miss_q;
    assign hit_pulse = hit_q;
    assign saturated = sat_q;
endmodule
